rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we/rd/wd) between two sources:
  - the pipeline Write Back stage, which cannot stall;
  - the long-latency multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO until the port is free.
- Keeps a pending-destination scoreboard so the decode stage can stall on hazards against in-flight MDU ops.
- Requests a pipeline bubble when an MDU result waits too long.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, >=2).
- MAX_WAIT, 4, consecutive blocked cycles before stall_req asserts (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  Write Back stage has a result
- wb_rd  in  5  Write Back destination
- wb_data  in  32  Write Back data
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  arbiter accepts MDU result
- mdu_rd  in  5  MDU destination
- mdu_data  in  32  MDU data
- issue_valid  in  1  MDU op issued this cycle
- issue_rd  in  5  destination of issued MDU op
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wd  out  32  register-file write data
- pend_mask  out  32  bit i = MDU write to xi outstanding
- stall_req  out  1  request a pipeline bubble

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; pend_mask=0; wait counter=0; stall_req=0.
  - Outputs during reset: mdu_ready=1, rf_we=0.
- rf_we, rf_rd and rf_wd are combinational; the register file writes them at the same clock edge (zero added latency).
- x0 rule:
  - Any source with rd==0 is treated as no write.
  - An MDU result to x0 is accepted (handshake completes) and discarded: not enqueued, no rf_we, pend_mask untouched.
- Write-port priority, evaluated each cycle:
  1. wb_valid && wb_rd!=0: write wb_rd/wb_data.
  2. Else if FIFO non-empty: write the head and pop it.
  3. Else if mdu_valid && mdu_rd!=0 (FIFO empty): fall-through; write mdu_rd/mdu_data directly, nothing enqueued.
  4. Else rf_we=0; rf_rd and rf_wd are don't-care, driven 0.
- MDU handshake:
  - Transfer occurs when mdu_valid && mdu_ready.
  - mdu_ready = (FIFO occupancy < DEPTH), from registered occupancy only; no combinational path from the valid inputs.
  - An accepted result not written through fall-through is pushed.
  - A push and a pop in the same cycle are legal; occupancy is unchanged.
  - Order preserved: the FIFO drains in acceptance order, and fall-through happens only when the FIFO is empty.
- Scoreboard:
  - On issue_valid && issue_rd!=0, set pend_mask[issue_rd].
  - When an MDU result is written to the register file (pop or fall-through), clear pend_mask[rd].
  - A set and a clear of the same bit in one cycle: set wins.
  - Issuing to an already-pending rd is a protocol violation; decode stalls on pend_mask. Flag it with a simulation assertion.
- Starvation:
  - Counter increments (saturating at MAX_WAIT) each cycle the FIFO is non-empty and no pop occurs.
  - Counter clears to 0 on a pop or when the FIFO is empty.
  - stall_req is registered: 1 in the cycle after the counter reaches MAX_WAIT, held until the cycle after the next pop.
- Reset mid-operation: FIFO contents and pend_mask are discarded immediately. Upstream must flush MDU ops together with reset.

Test Plan:
- Reset, then idle -> mdu_ready=1, rf_we=0, pend_mask=0, stall_req=0.
- wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF while mdu_valid=1, mdu_rd=7, FIFO empty:
  - same cycle: rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; MDU result enqueued;
  - next idle cycle: rf_rd=7 written, pend_mask[7] cleared.
- wb_valid held 1 (rd!=0) with three MDU results offered, DEPTH=2:
  - two are accepted, then mdu_ready=0;
  - with MAX_WAIT=4, stall_req=1 five cycles after the first enqueue;
  - after wb_valid drops, the two pops occur in order, and stall_req=0 the cycle after the first pop.
- Issue with issue_rd=0 and an MDU result to x0 -> pend_mask unchanged, rf_we=0, handshake completes.
- issue_valid, issue_rd=9 in the same cycle as an MDU fall-through write to x9 -> pend_mask[9]=1 after the edge.
- Assert rst with 2 FIFO entries and pend_mask=0x0000_0300 -> immediately FIFO empty, pend_mask=0, mdu_ready=1, no register-file writes afterward.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between Write Back and a FIFO-buffered MDU, with a pending-destination scoreboard
module rf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic [31:0] pend_mask,
    output logic        stall_req
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic [WW-1:0] wcnt;
    logic          wb_w, empty, acc, ft, push, pop;
    logic [31:0]   set, clr;

    assign mdu_ready = cnt < FULL;

    always_comb begin
        wb_w  = wb_valid && wb_rd != 5'd0;
        empty = cnt == '0;
        acc   = mdu_valid && mdu_ready;
        pop   = !wb_w && !empty;
        ft    = !wb_w && empty && acc && mdu_rd != 5'd0;
        push  = acc && mdu_rd != 5'd0 && !ft;
        rf_we = !rst && (wb_w || pop || ft);
        rf_rd = wb_w ? wb_rd : pop ? mem[rp][36:32] : ft ? mdu_rd : 5'd0;
        rf_wd = wb_w ? wb_data : pop ? mem[rp][31:0] : ft ? mdu_data : 32'd0;
        set   = (issue_valid && issue_rd != 5'd0) ? 32'd1 << issue_rd : 32'd0;
        clr   = (pop || ft) ? 32'd1 << rf_rd : 32'd0;
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= {mdu_rd, mdu_data};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            stall_req <= 1'b0;
            pend_mask <= 32'd0;
        end else begin
            wp        <= push ? wp + AW'(1) : wp;
            rp        <= pop ? rp + AW'(1) : rp;
            cnt       <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            wcnt      <= (empty || pop) ? '0 : (wcnt == WMAX) ? wcnt : wcnt + WW'(1);
            stall_req <= pop ? 1'b0 : (wcnt == WMAX) ? 1'b1 : stall_req;
            pend_mask <= (pend_mask & ~clr) | set;
        end

    // decode must stall on pend_mask, so re-issuing to a pending rd is illegal
    a_no_reissue: assert property (@(posedge clk) disable iff (rst)
        issue_valid && issue_rd != 5'd0 |-> !pend_mask[issue_rd]);
endmodule
